// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single SDRAM controller request port between the instruction
//   fetch requester (I) and the data load/store requester (D). One transaction
//   is in flight at a time: grant, issue the command (valid/ready), wait for
//   the response pulse, then pulse the owner's done for one cycle.
//   D normally wins a collision; after STARVE_LIMIT consecutive D grants made
//   while I is waiting, I is forced through. A watchdog aborts a transaction
//   that spends TIMEOUT cycles in ISSUE+WAIT without completing.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   i_req, i_addr              fetch request / byte address
//   i_done, i_rdata            fetch done pulse / fetched word
//   d_req, d_we, d_oplen,
//   d_addr, d_wdata            data request, store flag, size code, address, store data
//   d_done, d_rdata            data done pulse / load data (0 for stores)
//   m_valid, m_ready           command handshake to the controller
//   m_we, m_oplen, m_addr,
//   m_wdata                    registered command fields
//   m_resp, m_rdata            controller response pulse / read data
//   busy                       transaction in progress
//   timeout_err                pulses with the done of an aborted transaction
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [24:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_oplen,
    input  logic [24:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_we,
    output logic [1:0]  m_oplen,
    output logic [24:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_resp,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);
    // Fetches are always full words.
    localparam logic [1:0]  I_OPLEN    = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t      state;
    logic        owner_d;
    logic [3:0]  starve_cnt;
    logic [15:0] wd_cnt;

    logic        grant_d;
    logic        fin;
    logic        fin_to;
    logic [31:0] fin_data;

    // D wins a collision unless I has been passed over STARVE_LIMIT times.
    always_comb begin
        grant_d = d_req && !(i_req && (starve_cnt == STARVE_MAX));
    end

    // Completion of the current transaction. A response in WAIT beats the
    // watchdog; in ISSUE an acceptance beats it. Once expired, the count stays
    // at or past WD_LAST, so a command accepted on the expiry cycle still
    // gets exactly one WAIT cycle to answer before it is aborted.
    always_comb begin
        fin      = 1'b0;
        fin_to   = 1'b0;
        fin_data = 32'd0;
        if (state == S_WAIT && m_resp) begin
            fin      = 1'b1;
            fin_data = m_we ? 32'd0 : m_rdata;
        end else if (((state == S_ISSUE && !m_ready) || state == S_WAIT) &&
                     (wd_cnt >= WD_LAST)) begin
            fin    = 1'b1;
            fin_to = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            owner_d     <= 1'b0;
            starve_cnt  <= 4'd0;
            wd_cnt      <= 16'd0;
            busy        <= 1'b0;
            m_valid     <= 1'b0;
            m_we        <= 1'b0;
            m_oplen     <= 2'd0;
            m_addr      <= 25'd0;
            m_wdata     <= 32'd0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            i_rdata     <= 32'd0;
            d_rdata     <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        state   <= S_ISSUE;
                        busy    <= 1'b1;
                        m_valid <= 1'b1;
                        wd_cnt  <= 16'd0;
                        owner_d <= grant_d;
                        if (grant_d) begin
                            m_we    <= d_we;
                            m_oplen <= d_oplen;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            if (i_req && starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + 4'd1;
                        end else begin
                            m_we       <= 1'b0;
                            m_oplen    <= I_OPLEN;
                            m_addr     <= i_addr;
                            m_wdata    <= 32'd0;
                            starve_cnt <= 4'd0;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    // Cannot wrap: at most WD_LAST+1 <= 65535.
                    wd_cnt <= wd_cnt + 16'd1;
                    if (fin) begin
                        state       <= S_DONE;
                        m_valid     <= 1'b0;
                        i_done      <= !owner_d;
                        d_done      <= owner_d;
                        timeout_err <= fin_to;
                        if (owner_d) d_rdata <= fin_data;
                        else         i_rdata <= fin_data;
                    end else if (state == S_ISSUE && m_ready) begin
                        state   <= S_WAIT;
                        m_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    i_done      <= 1'b0;
                    d_done      <= 1'b0;
                    timeout_err <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations
// plus a transaction-level reference model compared on every falling edge.
module tb_mem_port_arbiter;

    localparam int  STARVE_LIMIT = 4;
    localparam int  TIMEOUT      = 8;
    localparam byte CH_I = "I";
    localparam byte CH_D = "D";

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [24:0] i_addr = '0, d_addr = '0;
    logic [1:0]  d_oplen = '0;
    logic [31:0] d_wdata = '0;
    logic        m_ready = 1'b0, m_resp = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        i_done, d_done, m_valid, m_we, busy, timeout_err;
    logic [31:0] i_rdata, d_rdata, m_wdata;
    logic [1:0]  m_oplen;
    logic [24:0] m_addr;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_oplen(d_oplen), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_oplen(m_oplen),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction timestamps) ----------------
    // A transaction is: granted at cycle tg, accepted at cycle ta (-1 until then),
    // resolved (response or abort) -> its done cycle is the next one.
    bit          mdl_in = 1'b0, mdl_res = 1'b0, mdl_own_d = 1'b0, mdl_we = 1'b0, mdl_terr = 1'b0;
    int          tg = 0, ta = -1, starve = 0;
    logic [24:0] mdl_addr = '0;
    logic [1:0]  mdl_oplen = '0;
    logic [31:0] mdl_wdata = '0, mdl_irdata = '0, mdl_drdata = '0;

    task automatic mdl_finish(input logic [31:0] data, input bit to);
        mdl_res  = 1'b1;
        mdl_terr = to;
        if (mdl_own_d) mdl_drdata = data;
        else           mdl_irdata = data;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mdl_in = 0; mdl_res = 0; mdl_terr = 0; ta = -1; starve = 0;
                mdl_irdata = '0; mdl_drdata = '0;
            end else if (mdl_in) begin
                if (mdl_res) begin
                    mdl_in = 0;                       // the done cycle just ended
                end else begin
                    if (ta < 0) begin
                        if (m_ready) ta = cyc;
                    end else if (m_resp) begin
                        mdl_finish(mdl_we ? 32'd0 : m_rdata, 1'b0);
                    end
                    // TIMEOUT cycles (tg+1 .. tg+TIMEOUT) allowed before abort;
                    // an acceptance on the last cycle gets one more WAIT cycle.
                    if (!mdl_res && ta != cyc && cyc >= tg + TIMEOUT)
                        mdl_finish(32'd0, 1'b1);
                end
            end else if (i_req || d_req) begin
                mdl_own_d = d_req && !(i_req && starve == STARVE_LIMIT);
                if (mdl_own_d) begin
                    if (i_req && starve < STARVE_LIMIT) starve++;
                    mdl_we = d_we; mdl_oplen = d_oplen; mdl_addr = d_addr; mdl_wdata = d_wdata;
                end else begin
                    starve = 0;
                    mdl_we = 1'b0; mdl_addr = i_addr;
                end
                mdl_in = 1; mdl_res = 0; mdl_terr = 0; tg = cyc; ta = -1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cmp1("mdl_busy", busy, mdl_in);
            cmp1("mdl_m_valid", m_valid, mdl_in && ta < 0 && !mdl_res);
            cmp1("mdl_i_done", i_done, mdl_in && mdl_res && !mdl_own_d);
            cmp1("mdl_d_done", d_done, mdl_in && mdl_res && mdl_own_d);
            cmp1("mdl_timeout_err", timeout_err, mdl_in && mdl_res && mdl_terr);
            cmp32("mdl_i_rdata", i_rdata, mdl_irdata);
            cmp32("mdl_d_rdata", d_rdata, mdl_drdata);
            if (mdl_in && ta < 0 && !mdl_res) begin
                cmp32("mdl_m_addr", 32'(m_addr), 32'(mdl_addr));
                cmp1("mdl_m_we", m_we, mdl_we);
                if (mdl_own_d) begin
                    cmp32("mdl_m_oplen", 32'(m_oplen), 32'(mdl_oplen));
                    cmp32("mdl_m_wdata", m_wdata, mdl_wdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit          auto_ctrl = 0, auto_drop_i = 1, auto_drop_d = 1;
    bit          prev_mv = 0, saw_i_done = 0, saw_d_done = 0;
    logic [31:0] rdata_seq = 32'h1000_0000;
    byte         grants[$];
    int          grant_cyc[$];
    byte         done_own[$];
    int          done_cyc[$];

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    // auto_ctrl: controller accepts at once and responds the cycle after.
    task automatic step();
        logic acc;
        acc = m_valid && m_ready;
        @(posedge clk);
        #1;
        if (auto_ctrl) begin
            m_ready = 1'b1;
            m_resp  = acc;
            if (acc) begin
                rdata_seq = rdata_seq + 32'h0123_4567;
                m_rdata   = rdata_seq;
            end else begin
                m_rdata = 32'd0;
            end
        end
        if (m_valid && !prev_mv) begin
            grants.push_back((m_addr == i_addr) ? CH_I : CH_D);
            grant_cyc.push_back(cyc);
        end
        prev_mv = m_valid;
        if (i_done) begin
            done_own.push_back(CH_I); done_cyc.push_back(cyc); saw_i_done = 1;
            if (auto_drop_i) i_req = 1'b0;
        end
        if (d_done) begin
            done_own.push_back(CH_D); done_cyc.push_back(cyc); saw_d_done = 1;
            if (auto_drop_d) d_req = 1'b0;
        end
    endtask

    task automatic clear_logs();
        grants.delete(); grant_cyc.delete(); done_own.delete(); done_cyc.delete();
        saw_i_done = 0; saw_d_done = 0;
    endtask

    byte exp_starve [6] = '{CH_D, CH_D, CH_D, CH_D, CH_I, CH_D};

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp1("reset_busy", busy, 1'b0);
        cmp1("reset_m_valid", m_valid, 1'b0);
        cmp1("reset_done", i_done | d_done, 1'b0);
        cmp1("reset_timeout_err", timeout_err, 1'b0);
        cmp32("reset_rdata", i_rdata | d_rdata, 32'd0);
        rst_n = 1'b1;
        step(); step();

        // single fetch, minimum latency
        clear_logs();
        i_addr = 25'h0000100; i_req = 1'b1;
        step();                                    // cycle 1: ISSUE
        cmp1("fetch_c1_m_valid", m_valid, 1'b1);
        cmp32("fetch_c1_m_addr", 32'(m_addr), 32'h0000100);
        cmp1("fetch_c1_m_we", m_we, 1'b0);
        m_ready = 1'b1;
        step();                                    // cycle 2: WAIT
        cmp1("fetch_c2_m_valid", m_valid, 1'b0);
        m_ready = 1'b0; m_resp = 1'b1; m_rdata = 32'h00500093;
        step();                                    // cycle 3: DONE
        m_resp = 1'b0; m_rdata = 32'd0;
        cmp1("fetch_c3_i_done", i_done, 1'b1);
        cmp32("fetch_c3_i_rdata", i_rdata, 32'h00500093);
        step();
        cmp1("fetch_c4_i_done", i_done, 1'b0);
        cmp1("fetch_c4_busy", busy, 1'b0);
        step();
        cmp1("fetch_no_d_done", saw_d_done, 1'b0);

        // collision: D first, I in the IDLE after d_done
        clear_logs();
        auto_ctrl = 1;
        i_addr = 25'h0000200; d_addr = 25'h0000300; d_we = 1'b0; d_oplen = 2'd2;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 40 && done_own.size() < 2; k++) step();
        cmp32("collision_ndone", 32'(done_own.size()), 32'd2);
        if (grants.size() >= 2 && done_own.size() >= 2) begin
            cmp32("collision_grant0", 32'(grants[0]), 32'(CH_D));
            cmp32("collision_grant1", 32'(grants[1]), 32'(CH_I));
            cmp32("collision_done0", 32'(done_own[0]), 32'(CH_D));
            cmp32("collision_i_issue_gap", 32'(grant_cyc[1] - done_cyc[0]), 32'd2);
        end
        step(); step();

        // starvation: D re-requests continuously while I waits
        clear_logs();
        auto_drop_d = 0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 200 && grants.size() < 6; k++) step();
        auto_drop_d = 1;
        for (int k = 0; k < 40 && busy; k++) step();
        step();
        cmp32("starve_ngrants", 32'(grants.size()), 32'd6);
        if (grants.size() >= 6)
            for (int k = 0; k < 6; k++)
                cmp32($sformatf("starve_grant%0d", k), 32'(grants[k]), 32'(exp_starve[k]));
        cmp1("starve_idle", busy, 1'b0);

        // backpressure and timeout
        clear_logs();
        auto_ctrl = 0; m_ready = 1'b0; m_resp = 1'b0;
        d_we = 1'b0; d_addr = 25'h0000400; d_req = 1'b1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            cmp1($sformatf("timeout_c%0d_m_valid", k), m_valid, 1'b1);
            cmp32($sformatf("timeout_c%0d_m_addr", k), 32'(m_addr), 32'h0000400);
        end
        step();                                    // cycle TIMEOUT+1
        cmp1("timeout_d_done", d_done, 1'b1);
        cmp1("timeout_err", timeout_err, 1'b1);
        cmp32("timeout_d_rdata", d_rdata, 32'd0);
        step();
        cmp1("timeout_err_pulse", timeout_err, 1'b0);
        saw_d_done = 0; saw_i_done = 0;
        m_resp = 1'b1; m_rdata = 32'hCAFE0001;
        step();
        m_resp = 1'b0;
        repeat (4) step();
        cmp1("stray_resp_no_done", saw_d_done | saw_i_done, 1'b0);

        // store with backpressure
        clear_logs();
        d_we = 1'b1; d_oplen = 2'd2; d_wdata = 32'hDEADBEEF; d_addr = 25'h0000500; d_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            cmp1($sformatf("store_c%0d_m_valid", k), m_valid, 1'b1);
            cmp32($sformatf("store_c%0d_m_wdata", k), m_wdata, 32'hDEADBEEF);
            cmp32($sformatf("store_c%0d_m_oplen", k), 32'(m_oplen), 32'd2);
            if (k == 4) m_ready = 1'b1;
        end
        step();                                    // WAIT
        m_ready = 1'b0;
        cmp1("store_wait_m_valid", m_valid, 1'b0);
        m_resp = 1'b1; m_rdata = 32'hFFFF0000;
        step();                                    // DONE
        m_resp = 1'b0;
        cmp1("store_d_done", d_done, 1'b1);
        cmp32("store_d_rdata", d_rdata, 32'd0);
        d_we = 1'b0;
        step(); step();

        // reset in WAIT, then recovery
        clear_logs();
        i_addr = 25'h0000600; i_req = 1'b1;
        step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        cmp1("rstwait_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        cmp1("rstwait_busy", busy, 1'b0);
        cmp1("rstwait_m_valid", m_valid, 1'b0);
        cmp1("rstwait_done", i_done | d_done, 1'b0);
        step();
        rst_n = 1'b1;
        auto_ctrl = 1;
        for (int k = 0; k < 20 && !saw_i_done; k++) step();
        cmp1("rstwait_recover_done", saw_i_done, 1'b1);
        cmp32("rstwait_recover_rdata", i_rdata, rdata_seq);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
